// File: rtl/add_seq_arb.sv
// add_seq_arb: two-requester round-robin arbiter in front of a 64-bit adder
// that is built from one 32-bit adder used twice (low half, then high half).
//
// Parameters
//   RR_INIT     requester that holds round-robin priority after reset (0 or 1)
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   reqN_valid  requester N has an operation pending (N = 0, 1)
//   reqN_ready  requester N's operands are accepted this cycle (IDLE only)
//   reqN_a/b    64-bit operands of requester N
//   reqN_cin    carry-in of requester N
//   res_valid   result available (DONE only)
//   res_ready   consumer accepts the result
//   res_id      requester that owns the result
//   res_sum     64-bit sum, modulo 2^64
//   res_cout    carry out of bit 63
//   busy        high in every state except IDLE, low while rst is high
//   res_ovf     signed overflow of the 64-bit add (only with ADD_SEQ_OVF_EN)
// Configuration
//   ADD_SEQ_OVF_EN  define to add the res_ovf output

module add32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

module add_seq_arb #(
   parameter bit RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req0_a,
   input  logic [63:0] req0_b,
   input  logic        req0_cin,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [63:0] req1_a,
   input  logic [63:0] req1_b,
   input  logic        req1_cin,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        res_id,
   output logic [63:0] res_sum,
   output logic        res_cout,
   output logic        busy
`ifdef ADD_SEQ_OVF_EN
   ,
   output logic        res_ovf
`endif
);
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
   state_t      state_q, state_d;
   logic [63:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic        cin_q, cin_d, id_q, id_d, carry_q, carry_d;
   logic        cout_q, cout_d, prio_q, prio_d;
   logic        idle, hi, take0, take1;
   logic [31:0] add_a, add_b, add_s;
   logic        add_cin, add_co;
`ifdef ADD_SEQ_OVF_EN
   logic        ovf_q, ovf_d;
`endif
   assign idle = (state_q == IDLE) && !rst;
   assign hi   = state_q == HI;
   // requester 1 wins when it is alone or when both are valid and it holds priority
   assign req1_ready = idle && req1_valid && (!req0_valid || prio_q);
   assign req0_ready = idle && req0_valid && (!req1_valid || !prio_q);
   assign take0 = req0_valid && req0_ready;
   assign take1 = req1_valid && req1_ready;
   // the single adder works on the low half in LO and on the high half in HI
   assign add_a   = hi ? a_q[63:32] : a_q[31:0];
   assign add_b   = hi ? b_q[63:32] : b_q[31:0];
   assign add_cin = hi ? carry_q : cin_q;
   add32 u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .s    (add_s),
      .cout (add_co)
   );
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      id_d    = id_q;
      prio_d  = prio_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef ADD_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: if (take0 || take1) begin
            a_d     = take1 ? req1_a : req0_a;
            b_d     = take1 ? req1_b : req0_b;
            cin_d   = take1 ? req1_cin : req0_cin;
            id_d    = take1;
            prio_d  = !take1;
            state_d = LO;
         end
         LO: begin
            sum_d[31:0] = add_s;
            carry_d     = add_co;
            state_d     = HI;
         end
         HI: begin
            sum_d[63:32] = add_s;
            cout_d       = add_co;
`ifdef ADD_SEQ_OVF_EN
            // carry into bit 63 recovered from the sum bit, compared with carry out
            ovf_d        = (a_q[63] ^ b_q[63] ^ add_s[31]) ^ add_co;
`endif
            state_d      = DONE;
         end
         DONE: state_d = res_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         id_q    <= 1'b0;
         prio_q  <= RR_INIT;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         id_q    <= id_d;
         prio_q  <= prio_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef ADD_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end
   assign res_valid = state_q == DONE;
   assign res_id    = id_q;
   assign res_sum   = sum_q;
   assign res_cout  = cout_q;
   assign busy      = (state_q != IDLE) && !rst;
`ifdef ADD_SEQ_OVF_EN
   assign res_ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_add_seq_arb.sv
// tb_add_seq_arb: directed self-checking bench for add_seq_arb
module tb_add_seq_arb;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
   logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_cin = 1'b0, req1_cin = 1'b0;
   logic        req0_ready, req1_ready, res_valid, res_id, res_cout, busy;
   logic [63:0] res_sum;
`ifdef ADD_SEQ_OVF_EN
   logic        res_ovf;
`endif
   int checks = 0, failures = 0;
   add_seq_arb #(.RR_INIT(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_id     (res_id),
      .res_sum    (res_sum),
      .res_cout   (res_cout),
      .busy       (busy)
`ifdef ADD_SEQ_OVF_EN
      ,
      .res_ovf    (res_ovf)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic set_req(input int who, input logic [63:0] a, input logic [63:0] b, input logic c);
      if (who == 0) begin
         req0_a = a; req0_b = b; req0_cin = c; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_cin = c; req1_valid = 1'b1;
      end
   endtask
   // one op from a lone requester with res_ready high: exact latency is checked
   task automatic single_op(input int who, input logic [63:0] a, input logic [63:0] b, input logic c,
                            input logic [63:0] es, input logic ec, input logic eo);
      @(negedge clk);
      set_req(who, a, b, c);
      #1;
      check("ready0_grant", req0_ready, who == 0);
      check("ready1_grant", req1_ready, who == 1);
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("lo_busy", busy, 1);
      check("lo_no_valid", res_valid, 0);
      @(negedge clk);
      check("hi_no_valid", res_valid, 0);
      @(negedge clk);
      check("done_valid", res_valid, 1);
      check("done_sum", res_sum, es);
      check("done_cout", res_cout, ec);
      check("done_id", res_id, who[0]);
`ifdef ADD_SEQ_OVF_EN
      check("done_ovf", res_ovf, eo);
`else
      if (eo) $display("note: overflow expected but res_ovf not built");
`endif
      @(negedge clk);
      check("back_idle", busy, 0);
      check("idle_no_valid", res_valid, 0);
   endtask
   initial begin
      req0_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready0", req0_ready, 0);
      check("rst_busy", busy, 0);
      req0_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("reset_valid", res_valid, 0);
      check("reset_sum", res_sum, 0);
      check("reset_cout", res_cout, 0);
      check("reset_id", res_id, 0);
      check("reset_busy", busy, 0);
      single_op(0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
      single_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
`ifdef ADD_SEQ_OVF_EN
      single_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      single_op(1, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
`endif
      // backpressure: priority is back at requester 0, so it wins against requester 1
      @(negedge clk);
      res_ready = 1'b0;
      set_req(0, 64'hDEAD_BEEF_CAFE_F00D, 64'h3, 1'b0);
      set_req(1, 64'h5, 64'h6, 1'b0);
      #1;
      check("bp_ready0", req0_ready, 1);
      check("bp_ready1", req1_ready, 0);
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", res_valid, 1);
         check("bp_sum", res_sum, 64'hDEAD_BEEF_CAFE_F010);
         check("bp_cout", res_cout, 0);
         check("bp_id", res_id, 0);
         check("bp_rdy0", req0_ready, 0);
         check("bp_rdy1", req1_ready, 0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      req1_valid = 1'b0;
      @(negedge clk);
      check("bp_release", busy, 0);
      check("bp_rel_valid", res_valid, 0);
      // reset while in HI aborts the op
      set_req(1, 64'h1234, 64'h4321, 1'b1);
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      check("abort_valid", res_valid, 0);
      check("abort_sum", res_sum, 0);
      check("abort_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_silent", res_valid, 0);
      end
      // contention: both valid throughout, priority starts at 0 after reset
      set_req(0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1);
      set_req(1, 64'hFFFF_FFFF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b0);
      #1;
      for (int k = 0; k < 4; k++) begin
         check("rr_ready0", req0_ready, k % 2 == 0);
         check("rr_ready1", req1_ready, k % 2 == 1);
         repeat (3) @(negedge clk);
         check("rr_valid", res_valid, 1);
         check("rr_id", res_id, k % 2);
         check("rr_sum", res_sum, (k % 2 == 0) ? 64'h1234_5678_9ABC_DF01 : 64'h0000_0001_0000_0000);
         check("rr_cout", res_cout, k % 2 == 1);
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/add_seq_arb.md
ADD_SEQ_ARB -- requirements
Module: add_seq_arb

Interface
REQ-001 Parameter: RR_INIT, 0, requester holding round-robin priority after reset (0 or 1).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  block accepts requester n's operands this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  64  operands A and B for requester n.
REQ-007 req0_cin / req1_cin  input  1  carry-in for requester n.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts result.
REQ-010 res_id  output  1  index of requester that owns the result.
REQ-011 res_sum  output  64  64-bit sum.
REQ-012 res_cout  output  1  carry-out of bit 63.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 Shall contain exactly one 32-bit adder instance (32-bit A, 32-bit B, cin, 32-bit sum, cout), time-shared across both halves and both requesters.
REQ-015 FSM states: IDLE, LO, HI, DONE; encoding left to implementer.
REQ-016 IDLE: if any reqN_valid, grant one; reqN_ready = 1 for granted requester only, combinationally, only in IDLE.
REQ-017 Transfer occurs when reqN_valid & reqN_ready; operands, cin and id are latched and state moves to LO.
REQ-018 Arbitration: single valid requester wins; both valid -> priority holder wins; after each grant, priority passes to the non-granted requester.
REQ-019 LO: adder computes A[31:0]+B[31:0]+cin; sum stored to res_sum[31:0], cout to internal carry register; next HI.
REQ-020 HI: adder computes A[63:32]+B[63:32]+stored carry; sum stored to res_sum[63:32], cout to res_cout; next DONE.
REQ-021 DONE: res_valid = 1; res_sum, res_cout, res_id held stable until res_valid & res_ready, then IDLE.
REQ-022 Latency: transfer at edge T -> res_valid high after edge T+2; with res_ready held high, next transfer no earlier than edge T+4.
REQ-023 res_valid shall never be high outside DONE; reqN_ready never high outside IDLE.
REQ-024 Arithmetic is unsigned modulo 2^64; res_cout equals bit 64 of A+B+cin.
REQ-025 Valid-drop: a requester deasserting valid while not granted loses nothing and gains no priority.

Reset
REQ-026 rst high at a rising edge: state -> IDLE, res_valid, res_id, res_sum, res_cout, carry register -> 0, priority -> RR_INIT.
REQ-027 rst mid-operation (LO, HI or DONE) aborts the transaction; no result is produced for it.
REQ-028 While rst is high, reqN_ready = 0 and busy = 0.

Configuration
REQ-029 Macro ADD_SEQ_OVF_EN: when defined, adds output res_ovf (1 bit) = signed two's-complement overflow of the 64-bit add (carry into bit 63 XOR carry out of bit 63), registered in HI, held in DONE, reset to 0.
REQ-030 Without ADD_SEQ_OVF_EN: port res_ovf absent; all other behaviour identical.

Verification
REQ-031 Single op: req0 A=0x0000_0000_FFFF_FFFF, B=1, cin=0 -> res_sum=0x0000_0001_0000_0000, res_cout=0, res_id=0, res_valid after edge T+2.
REQ-032 Full carry: req1 A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> res_sum=0, res_cout=1, res_id=1; with macro, res_ovf=0.
REQ-033 Contention: both valid continuously, RR_INIT=0, res_ready=1 -> grant order 0,1,0,1 across four ops; results tagged accordingly.
REQ-034 Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid, res_sum, res_cout stable; both reqN_ready=0 throughout; one cycle after res_ready=1 returns to IDLE.
REQ-035 Reset mid-op: rst asserted in HI -> next cycle IDLE, res_valid=0, res_sum=0, busy=0; the aborted op is never reported.
REQ-036 Overflow (macro defined): A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 -> res_sum=0x8000_0000_0000_0000, res_ovf=1, res_cout=0.
